frame_writer: RTL and testbench
===============================

# frame_writer

Receives the read-out stream that the pixel iterator pulls from the multi-solver: solver id, solver address, read data and end-of-stream. It rebuilds each raster pixel index, maps the iteration count to an 8-bit colour, and writes the pixel into the frame buffer over a valid/ready port. A small FIFO absorbs frame-buffer backpressure, and a stall output throttles the iterator before any sample can be lost.

## Interface

- NUM_SOLVERS, 1, number of solvers interleaved across the frame (1..64)
- NUM_COLUMNS, 99, frame width in pixels
- NUM_ROWS, 66, frame height in pixels
- ITER_WIDTH, 16, width of solver read data (iteration count)
- MAX_ITER, 1000, iteration count at or above which a pixel is in the set
- READ_LATENCY, 2, cycles from address presented to rd_data valid
- FIFO_DEPTH, 8, output FIFO entries (power of two, at least READ_LATENCY+2)
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- en  input  1  iterator enable for this cycle (solver done AND NOT stall); qualifies solver_id/solver_addr
- solver_id  input  6  solver being read
- solver_addr  input  19  per-solver result address
- end_stream  input  1  high with the last address of the frame
- rd_data  input  ITER_WIDTH  solver read data, valid READ_LATENCY cycles after its address
- stall  output  1  iterator must not advance
- fb_valid  output  1  write pending
- fb_addr  output  19  raster pixel index, row*NUM_COLUMNS + column
- fb_data  output  8  pixel colour
- fb_ready  input  1  frame buffer accepts write
- frame_done  output  1  one-cycle pulse, full frame written
- overflow  output  1  sticky: sample lost to a full FIFO
- range_err  output  1  sticky: computed index at or beyond NUM_COLUMNS*NUM_ROWS

## Operation

- Pixel mapping is fixed: index p = solver_addr*NUM_SOLVERS + solver_id. p is computed in the cycle en is sampled and is 19 bits wide.
- Capture pipeline: en, p and end_stream are delayed by READ_LATENCY stages (p_valid, p_idx, p_end). At stage READ_LATENCY, rd_data is combined with the delayed index.
- Colour: rd_data >= MAX_ITER gives 8'h00. Otherwise the colour is min(rd_data, 255), zero-extended compare at ITER_WIDTH.
- Range check: if p >= NUM_COLUMNS*NUM_ROWS, the sample is dropped, range_err sets and stays set until reset. A dropped sample is not counted and not pushed.
- FIFO: each entry holds {fb_addr, fb_data, last}. A sample is pushed when its pipeline stage is valid and in range. A push into a full FIFO discards the sample and sets overflow (sticky).
- FIFO simultaneous push and pop when full: both occur, and no overflow is flagged.
- stall = (FIFO occupancy + samples in flight in the pipeline) >= FIFO_DEPTH - 1. This guarantees no overflow when the iterator honours stall.
- Output: fb_valid = FIFO not empty; fb_addr and fb_data come from the head. The head pops on fb_valid && fb_ready.
- Frame counter: written_count increments on every pop. frame_done pulses the cycle after the pop that makes written_count == NUM_COLUMNS*NUM_ROWS; the counter then clears to 0.
- A popped entry with last set while written_count is short still raises frame_done and clears the counter, which covers partial frames.
- Reset: clears the pipeline valids, FIFO pointers, counter and sticky flags. Any transaction in flight is abandoned.

## Timing

- Reset values: stall 0, fb_valid 0, fb_addr 0, fb_data 0, frame_done 0, overflow 0, range_err 0.
- Latency from en high at cycle t to fb_valid with an empty FIFO: fb_valid at t+READ_LATENCY+1.
- fb_addr and fb_data hold stable while fb_valid && !fb_ready.
- stall is registered and updates one cycle after the occupancy change that causes it.
- frame_done asserts exactly one cycle and never during reset.
- Reset asserted mid-frame: the next cycle shows all outputs at reset values. The following frame counts from 0.

## Test plan

- NUM_SOLVERS=1, fb_ready=1, full 99x66 sweep with rd_data = addr mod 1200:
  - 6534 writes, fb_addr 0..6533 in order.
  - fb_data = 0 wherever rd_data >= 1000, otherwise min(rd_data, 255).
  - A single frame_done after write 6534.
- NUM_SOLVERS=4, solver_id cycling 0..3 per addr: fb_addr = 4*addr+id. solver_addr=5, id=3 gives fb_addr 23. No range_err.
- Backpressure: hold fb_ready=0 with en honouring stall. stall rises before occupancy exceeds 7, overflow stays 0, the FIFO holds 8 entries. Releasing fb_ready drains them in order, 1 per cycle.
- Forced overflow: ignore stall, fb_ready=0, drive en for 12 cycles. Exactly 8 entries are retained, overflow=1 and stays set.
- Out of range: solver_addr=6534, id=0, NUM_SOLVERS=1. No fb write, range_err=1.
- Reset at write 3000 of a frame: outputs are zero the next cycle. A fresh full frame then gives exactly 6534 writes and one frame_done.

Source files
------------

// File: rtl/frame_writer.sv
// frame_writer
//   Rebuilds raster pixel indices from the multi-solver read-out stream, maps
//   each iteration count to an 8-bit colour and writes the pixel to the frame
//   buffer through a small FIFO that absorbs frame-buffer backpressure.
//
// Ports
//   clock, reset      sole clock (rising edge), synchronous active-high reset
//   en                iterator enable; qualifies solver_id / solver_addr
//   solver_id         solver being read
//   solver_addr       per-solver result address
//   end_stream        high with the last address of the frame
//   rd_data           solver read data, valid READ_LATENCY cycles after address
//   stall             registered throttle back to the iterator
//   fb_valid/fb_ready frame-buffer write handshake
//   fb_addr, fb_data  raster pixel index and colour at the FIFO head
//   frame_done        one-cycle pulse once a whole frame has been written
//   overflow          sticky: a sample was lost to a full FIFO
//   range_err         sticky: a computed index fell outside the frame
module frame_writer #(
  parameter int NUM_SOLVERS  = 1,
  parameter int NUM_COLUMNS  = 99,
  parameter int NUM_ROWS     = 66,
  parameter int ITER_WIDTH   = 16,
  parameter int MAX_ITER     = 1000,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [5:0]            solver_id,
  input  logic [18:0]           solver_addr,
  input  logic                  end_stream,
  input  logic [ITER_WIDTH-1:0] rd_data,
  output logic                  stall,
  output logic                  fb_valid,
  output logic [18:0]           fb_addr,
  output logic [7:0]            fb_data,
  input  logic                  fb_ready,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  range_err
);

  localparam int TOTAL = NUM_COLUMNS * NUM_ROWS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PEND_W = CNT_W + 1;
  localparam int LAST = READ_LATENCY - 1;

  logic [18:0] p_now;
  logic        p_valid [READ_LATENCY];
  logic [18:0] p_idx   [READ_LATENCY];
  logic        p_end   [READ_LATENCY];

  logic [7:0]  colour;
  logic        in_range;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        lost;

  logic [18:0] mem_addr [FIFO_DEPTH];
  logic [7:0]  mem_data [FIFO_DEPTH];
  logic        mem_last [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PEND_W-1:0] pending;
  logic [18:0] written_count;

  // Solvers are interleaved pixel by pixel, so the raster index is the
  // per-solver address scaled by the solver count plus the solver number.
  assign p_now = 19'(solver_addr * 19'(NUM_SOLVERS)) + 19'(solver_id);

  // Valid bits of the capture pipeline; only these need clearing on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) p_valid[i] <= 1'b0;
    end else begin
      p_valid[0] <= en;
      for (int i = 1; i < READ_LATENCY; i++) p_valid[i] <= p_valid[i-1];
    end
  end

  // Index and end marker ride alongside the valid bit until rd_data arrives.
  always_ff @(posedge clock) begin
    p_idx[0] <= p_now;
    p_end[0] <= end_stream;
    for (int i = 1; i < READ_LATENCY; i++) begin
      p_idx[i] <= p_idx[i-1];
      p_end[i] <= p_end[i-1];
    end
  end

  // Pixels inside the set are black; escaping pixels saturate at 255.
  always_comb begin
    colour = 8'h00;
    if (rd_data >= ITER_WIDTH'(MAX_ITER)) colour = 8'h00;
    else if (rd_data > ITER_WIDTH'(255)) colour = 8'hFF;
    else colour = rd_data[7:0];
  end

  assign count    = wr_ptr - rd_ptr;
  assign head     = rd_ptr[PTR_W-1:0];
  assign fb_valid = (count != '0);
  assign pop      = fb_valid && fb_ready;
  assign in_range = (p_idx[LAST] < 19'(TOTAL));
  assign push_req = p_valid[LAST] && in_range;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push     = push_req && ((count != CNT_W'(FIFO_DEPTH)) || pop);
  assign lost     = push_req && !push;

  // Head fields are masked while empty so stale storage never shows.
  assign fb_addr = fb_valid ? mem_addr[head] : 19'd0;
  assign fb_data = fb_valid ? mem_data[head] : 8'd0;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr[PTR_W-1:0]] <= p_idx[LAST];
      mem_data[wr_ptr[PTR_W-1:0]] <= colour;
      mem_last[wr_ptr[PTR_W-1:0]] <= p_end[LAST];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Samples already in the pipeline will land in the FIFO regardless of
  // stall, so they are reserved alongside the current occupancy.
  always_comb begin
    pending = PEND_W'(count);
    for (int i = 0; i < READ_LATENCY; i++) pending = pending + PEND_W'(p_valid[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall     <= 1'b0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      stall     <= (pending >= PEND_W'(FIFO_DEPTH - 1));
      overflow  <= overflow | lost;
      range_err <= range_err | (p_valid[LAST] && !in_range);
    end
  end

  // A frame ends on the last pixel by count, or early on an end marker.
  always_ff @(posedge clock) begin
    if (reset) begin
      written_count <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if ((written_count == 19'(TOTAL - 1)) || mem_last[head]) begin
          written_count <= '0;
          frame_done    <= 1'b1;
        end else begin
          written_count <= written_count + 19'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer
//   Directed bench for frame_writer with four interleaved solvers. Stimulus
//   pushes expected frame-buffer writes into a scoreboard queue; a monitor
//   pops and compares on every accepted write.
module tb_frame_writer;

  localparam int NS    = 4;
  localparam int TOTAL = 99 * 66;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  solver_id;
  logic [18:0] solver_addr;
  logic        end_stream;
  logic [15:0] rd_data;
  logic        stall;
  logic        fb_valid;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        frame_done;
  logic        overflow;
  logic        range_err;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int writes = 0;
  int dones = 0;
  int done_at = -1;
  logic [15:0] d_hist [2];

  frame_writer #(
    .NUM_SOLVERS(NS), .NUM_COLUMNS(99), .NUM_ROWS(66), .ITER_WIDTH(16),
    .MAX_ITER(1000), .READ_LATENCY(2), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .solver_id(solver_id),
    .solver_addr(solver_addr), .end_stream(end_stream), .rd_data(rd_data),
    .stall(stall), .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready), .frame_done(frame_done), .overflow(overflow),
    .range_err(range_err)
  );

  always #5 clock = ~clock;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] colour_of(input logic [15:0] d);
    if (d >= 16'd1000) return 8'd0;
    if (d > 16'd255) return 8'd255;
    return d[7:0];
  endfunction

  // Monitor: every accepted write is checked against the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (frame_done) begin
        dones++;
        done_at = writes;
      end
      if (fb_valid && fb_ready) begin
        writes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", fb_addr);
        end else begin
          e = sb.pop_front();
          checkOutput("fb_addr", 32'(fb_addr), 32'(e.addr));
          checkOutput("fb_data", 32'(fb_data), 32'(e.data));
        end
      end
    end
  end

  // One iterator cycle. rd_data replays the value issued two cycles ago,
  // modelling the solver memory read latency.
  task automatic applyStimulus(input logic v, input logic [18:0] addr,
                               input logic [5:0] id, input logic last,
                               input logic [15:0] dval, input logic push_exp,
                               input logic [18:0] exp_addr,
                               input logic [7:0] exp_data);
    exp_t e;
    rd_data     = d_hist[1];
    d_hist[1]   = d_hist[0];
    d_hist[0]   = v ? dval : 16'd0;
    en          = v;
    solver_addr = addr;
    solver_id   = id;
    end_stream  = last;
    if (v && push_exp) begin
      e.addr = exp_addr;
      e.data = exp_data;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 19'd0, 6'd0, 1'b0, 16'd0, 1'b0, 19'd0, 8'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || fb_valid); i++) idle(1);
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_fb_valid", 32'(fb_valid), 32'd0);
    checkOutput("rst_fb_addr", 32'(fb_addr), 32'd0);
    checkOutput("rst_fb_data", 32'(fb_data), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_range_err", 32'(range_err), 32'd0);
  endtask

  task automatic doReset();
    en = 1'b0;
    fb_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkResetOutputs();
    sb.delete();
    writes = 0;
    dones = 0;
    done_at = -1;
  endtask

  // Raster sweep: pixel p comes from solver p%NS at address p/NS.
  task automatic runSweep(input int n, input int last_at);
    for (int p = 0; p < n; p++)
      applyStimulus(1'b1, 19'(p / NS), 6'(p % NS), p == last_at,
                    16'(p % 1200), 1'b1, 19'(p), colour_of(16'(p % 1200)));
  endtask

  // Directed vectors: solver address, id, read data, expected index, colour.
  logic [18:0] v_addr [8] = '{19'd0, 19'd5, 19'd1, 19'd2, 19'd3, 19'd10, 19'd7, 19'd1633};
  logic [5:0]  v_id   [8] = '{6'd0, 6'd2, 6'd1, 6'd0, 6'd3, 6'd1, 6'd0, 6'd1};
  logic [15:0] v_dat  [8] = '{16'd0, 16'd256, 16'd999, 16'd1000, 16'd1001, 16'd65535, 16'd254, 16'd77};
  logic [18:0] v_eadr [8] = '{19'd0, 19'd22, 19'd5, 19'd8, 19'd15, 19'd41, 19'd28, 19'd6533};
  logic [7:0]  v_ecol [8] = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd254, 8'd77};

  initial begin
    int w0;
    int d0;
    int issued;
    d_hist[0] = 16'd0;
    d_hist[1] = 16'd0;
    en = 1'b0; solver_id = 6'd0; solver_addr = 19'd0; end_stream = 1'b0;
    rd_data = 16'd0; fb_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    $display("[TB] reset values");
    checkResetOutputs();

    $display("[TB] latency and hold under backpressure");
    applyStimulus(1'b1, 19'd5, 6'd3, 1'b0, 16'd255, 1'b1, 19'd23, 8'd255);
    checkOutput("lat_t1", 32'(fb_valid), 32'd0);
    idle(1);
    checkOutput("lat_t2", 32'(fb_valid), 32'd0);
    idle(1);
    checkOutput("lat_t3", 32'(fb_valid), 32'd1);
    idle(2);
    checkOutput("hold_addr", 32'(fb_addr), 32'd23);
    checkOutput("hold_data", 32'(fb_data), 32'd255);
    fb_ready = 1'b1;

    $display("[TB] directed mapping and colour vectors");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, v_addr[i], v_id[i], 1'b0, v_dat[i], 1'b1, v_eadr[i], v_ecol[i]);
    drain();
    checkOutput("range_err_clean", 32'(range_err), 32'd0);

    $display("[TB] out-of-range indices");
    w0 = writes;
    applyStimulus(1'b1, 19'd1633, 6'd2, 1'b0, 16'd5, 1'b0, 19'd0, 8'd0);
    applyStimulus(1'b1, 19'd6534, 6'd0, 1'b0, 16'd5, 1'b0, 19'd0, 8'd0);
    idle(5);
    checkOutput("oob_writes", 32'(writes - w0), 32'd0);
    checkOutput("oob_range_err", 32'(range_err), 32'd1);

    $display("[TB] partial frame ended by end_stream");
    d0 = dones;
    applyStimulus(1'b1, 19'd20, 6'd0, 1'b0, 16'd1, 1'b1, 19'd80, 8'd1);
    applyStimulus(1'b1, 19'd20, 6'd1, 1'b0, 16'd2, 1'b1, 19'd81, 8'd2);
    applyStimulus(1'b1, 19'd20, 6'd2, 1'b1, 16'd3, 1'b1, 19'd82, 8'd3);
    drain();
    idle(2);
    checkOutput("partial_done", 32'(dones - d0), 32'd1);
    checkOutput("partial_done_at", 32'(done_at), 32'(writes));
    doReset();

    $display("[TB] backpressure with stall honoured");
    issued = 0;
    for (int c = 0; c < 16; c++) begin
      if (!stall) begin
        applyStimulus(1'b1, 19'(100 + issued), 6'd0, 1'b0, 16'(issued),
                      1'b1, 19'(4 * (100 + issued)), 8'(issued));
        issued++;
      end else begin
        idle(1);
      end
    end
    checkOutput("bp_issued", 32'(issued), 32'd8);
    checkOutput("bp_stall", 32'(stall), 32'd1);
    checkOutput("bp_overflow", 32'(overflow), 32'd0);
    fb_ready = 1'b1;
    w0 = writes;
    idle(8);
    checkOutput("bp_drain_rate", 32'(writes - w0), 32'd8);
    checkOutput("bp_empty", 32'(fb_valid), 32'd0);

    $display("[TB] forced overflow ignoring stall");
    fb_ready = 1'b0;
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 19'(300 + i), 6'd1, 1'b0, 16'(10 + i),
                    i < 8, 19'(4 * (300 + i) + 1), 8'(10 + i));
    idle(3);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    fb_ready = 1'b1;
    w0 = writes;
    idle(10);
    checkOutput("ovf_retained", 32'(writes - w0), 32'd8);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("ovf_left", 32'(sb.size()), 32'd0);
    doReset();

    $display("[TB] reset in the middle of a frame");
    fb_ready = 1'b1;
    runSweep(3003, -1);
    checkOutput("mid_writes", 32'(writes), 32'd3000);
    checkOutput("mid_no_done", 32'(dones), 32'd0);
    doReset();

    $display("[TB] full frame sweep");
    fb_ready = 1'b1;
    runSweep(TOTAL, TOTAL - 1);
    drain();
    idle(2);
    checkOutput("frame_writes", 32'(writes), 32'(TOTAL));
    checkOutput("frame_dones", 32'(dones), 32'd1);
    checkOutput("frame_done_at", 32'(done_at), 32'(TOTAL));
    checkOutput("frame_range_err", 32'(range_err), 32'd0);
    checkOutput("frame_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
